// File: rtl/fix_trailer_if.sv
// fix_trailer_if: body-in / byte-out handshake bundle for the FIX trailer sequencer.
interface fix_trailer_if;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_last;
    logic       s_ready;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_last;
    logic       m_ready;
    modport slave (
        input  s_data, s_valid, s_last, m_ready,
        output s_ready, m_data, m_valid, m_last
    );
    modport master (
        output s_data, s_valid, s_last, m_ready,
        input  s_ready, m_data, m_valid, m_last
    );
endinterface

// File: rtl/fix_trailer_sequencer.sv
// fix_trailer_sequencer: passes a FIX body through and appends "10=nnn"+SOH with the mod-256 sum.
module fix_trailer_sequencer #(
    parameter logic [7:0] SOH_CHAR = 8'h01,
    parameter int         CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    fix_trailer_if.slave     bus,
    output logic             busy,
    output logic             err_nosoh,
    output logic [CNT_W-1:0] msg_count
);
    typedef enum logic [2:0] {BODY, T_1, T_0, T_EQ, D_H, D_T, D_U, T_SOH} state_t;
    state_t           state_q, state_d;
    logic [7:0]       sum_q, sum_d;
    logic [3:0]       dh_q, dh_d, dt_q, dt_d, du_q, du_d;
    logic             busy_q, busy_d, err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_body, s_rdy, m_vld, s_hs, m_hs;
    logic [7:0]       m_dat;
    always_comb begin
        in_body = state_q == BODY;
        s_rdy   = in_body && bus.m_ready && !rst;
        m_vld   = !rst && (in_body ? bus.s_valid : 1'b1);
        s_hs    = bus.s_valid && s_rdy;
        m_hs    = m_vld && bus.m_ready;
        case (state_q)
            T_1:     m_dat = 8'h31;
            T_0:     m_dat = 8'h30;
            T_EQ:    m_dat = 8'h3D;
            D_H:     m_dat = 8'h30 + {4'd0, dh_q};
            D_T:     m_dat = 8'h30 + {4'd0, dt_q};
            D_U:     m_dat = 8'h30 + {4'd0, du_q};
            T_SOH:   m_dat = SOH_CHAR;
            default: m_dat = bus.s_data;
        endcase
    end
    assign bus.s_ready = s_rdy;
    assign bus.m_valid = m_vld;
    assign bus.m_data  = m_dat;
    assign bus.m_last  = state_q == T_SOH;
    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        busy_d  = busy_q;
        err_d   = 1'b0;
        cnt_d   = cnt_q;
        dh_d    = dh_q;
        dt_d    = dt_q;
        du_d    = du_q;
        // sum_q holds the final checksum throughout the trailer; digits are split out while '1' is offered
        if (state_q == T_1) begin
            dh_d = 4'(sum_q / 8'd100);
            dt_d = 4'((sum_q / 8'd10) % 8'd10);
            du_d = 4'(sum_q % 8'd10);
        end
        if (in_body) begin
            if (s_hs) begin
                sum_d  = sum_q + bus.s_data;
                busy_d = 1'b1;
                if (bus.s_last) begin
                    state_d = T_1;
                    err_d   = bus.s_data != SOH_CHAR;
                end
            end
        end else if (m_hs) begin
            state_d = state_q == T_SOH ? BODY : state_t'(state_q + 3'd1);
            if (state_q == T_SOH) begin
                sum_d  = 8'd0;
                busy_d = 1'b0;
                cnt_d  = cnt_q + CNT_W'(1);
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BODY;
            sum_q   <= 8'd0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            dh_q    <= 4'd0;
            dt_q    <= 4'd0;
            du_q    <= 4'd0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            dh_q    <= dh_d;
            dt_q    <= dt_d;
            du_q    <= du_d;
        end
    end
    assign busy      = busy_q;
    assign err_nosoh = err_q;
    assign msg_count = cnt_q;
endmodule

// File: tb/tb_fix_trailer_sequencer.sv
// tb_fix_trailer_sequencer: directed + randomized messages checked against a string-level trailer model.
module tb_fix_trailer_sequencer;
    typedef logic [7:0] bq_t[$];
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        busy, err_nosoh;
    logic [15:0] msg_count;
    int          vec = 0, mis = 0, exp_cnt = 0;
    logic        busy_exp = 1'b0, err_exp = 1'b0;
    bq_t         q;

    fix_trailer_if bus_if();
    fix_trailer_sequencer #(.SOH_CHAR(8'h01), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .bus(bus_if),
        .busy(busy), .err_nosoh(err_nosoh), .msg_count(msg_count)
    );
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bq_t str2q(input string s);
        bq_t r;
        for (int i = 0; i < s.len(); i++) r.push_back(s[i] == 8'h7C ? 8'h01 : s[i]);
        return r;
    endfunction

    function automatic bq_t rand_msg();
        bq_t r;
        int n = $urandom_range(1, 20);
        for (int i = 0; i < n - 1; i++) r.push_back(8'($urandom));
        r.push_back(8'h01);
        return r;
    endfunction

    // mode 0: m_ready always high, 1: random m_ready, 2: m_ready low 3 cycles on the tens digit
    task automatic run_msg(input bq_t body, input int mode, input int abort_at);
        bq_t        ex = body;
        int         sum = 0, ii = 0, io = 0, cyc = 0, stall = 0;
        string      t;
        logic       pend = 1'b0, hold = 1'b0;
        logic [7:0] hold_d = 8'h00;
        foreach (body[i]) sum = (sum + int'(body[i])) % 256;
        t = $sformatf("10=%03d", sum);
        for (int i = 0; i < t.len(); i++) ex.push_back(t[i]);
        ex.push_back(8'h01);
        while (io < ex.size() && cyc < 2000) begin
            if (io == abort_at) return;
            @(negedge clk);
            cyc++;
            if (!pend) bus_if.s_valid = ii < body.size() && $urandom_range(0, 3) != 0;
            bus_if.s_data = ii < body.size() ? body[ii] : 8'h00;
            bus_if.s_last = ii == body.size() - 1;
            if (mode == 2 && io == body.size() + 4 && stall < 3) begin
                bus_if.m_ready = 1'b0;
                stall++;
            end else bus_if.m_ready = mode != 1 || $urandom_range(0, 3) != 0;
            #1;
            chk("busy", busy, busy_exp);
            chk("err_nosoh", err_nosoh, err_exp);
            if (hold) chk("m_data_held", bus_if.m_data, hold_d);
            hold   = bus_if.m_valid && !bus_if.m_ready;
            hold_d = bus_if.m_data;
            pend   = bus_if.s_valid && !bus_if.s_ready;
            err_exp = 1'b0;
            if (bus_if.s_valid && bus_if.s_ready) begin
                if (bus_if.s_last && bus_if.s_data != 8'h01) err_exp = 1'b1;
                busy_exp = 1'b1;
                ii++;
            end
            if (bus_if.m_valid && bus_if.m_ready) begin
                chk($sformatf("m_data[%0d]", io), bus_if.m_data, ex[io]);
                chk($sformatf("m_last[%0d]", io), bus_if.m_last, io == ex.size() - 1);
                if (io == ex.size() - 1) begin
                    busy_exp = 1'b0;
                    exp_cnt++;
                end
                io++;
            end
        end
        chk("bytes_out", io, ex.size());
        @(negedge clk);
        bus_if.s_valid = 1'b0;
        bus_if.m_ready = 1'b0;
        #1;
        chk("msg_count", msg_count, exp_cnt);
        chk("busy_idle", busy, busy_exp);
    endtask

    initial begin
        bus_if.s_valid = 1'b1;
        bus_if.s_data  = 8'h55;
        bus_if.s_last  = 1'b0;
        bus_if.m_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_m_valid", bus_if.m_valid, 0);
        chk("rst_s_ready", bus_if.s_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        bus_if.s_valid = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_err", err_nosoh, 0);
        chk("rst_msg_count", msg_count, 0);
        q = {8'h01};
        run_msg(q, 0, -1);
        q = {8'hFF, 8'hFF, 8'h01};
        run_msg(q, 0, -1);
        run_msg(str2q("8=FIX.4.2|9=5|35=0|"), 1, -1);
        q = rand_msg();
        run_msg(q, 2, -1);
        q = {8'h64};
        run_msg(q, 0, -1);
        q = rand_msg();
        run_msg(q, 1, q.size() + 3);
        @(negedge clk);
        rst = 1'b1;
        bus_if.s_valid = 1'b1;
        bus_if.s_data  = 8'h42;
        bus_if.m_ready = 1'b1;
        #1;
        chk("midrst_m_valid", bus_if.m_valid, 0);
        chk("midrst_s_ready", bus_if.s_ready, 0);
        @(negedge clk);
        #1;
        chk("midrst_m_valid2", bus_if.m_valid, 0);
        chk("midrst_s_ready2", bus_if.s_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        bus_if.s_valid = 1'b0;
        #1;
        exp_cnt  = 0;
        busy_exp = 1'b0;
        err_exp  = 1'b0;
        chk("postrst_m_valid", bus_if.m_valid, 0);
        chk("postrst_busy", busy, 0);
        chk("postrst_msg_count", msg_count, 0);
        run_msg(rand_msg(), 0, -1);
        run_msg(rand_msg(), 1, -1);
        for (int k = 0; k < 4; k++) run_msg(rand_msg(), 1, -1);
        $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
        $finish;
    end
endmodule
